// File: rtl/pcseq_pkg.sv
// Shared types and defaults for the program-counter next-address sequencer.
package pcseq_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam logic [ADDR_W-1:0] RESET_VEC = 8'h00;
    localparam logic [ADDR_W-1:0] IRQ_VEC   = 8'hF0;

    // Sequencer states
    typedef enum logic [1:0] {
        RST   = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Next-address source select
    typedef enum logic [2:0] {
        SEL_INC  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4,
        SEL_HOLD = 3'd5,
        SEL_VEC  = 3'd6,
        SEL_RST  = 3'd7
    } sel_t;

endpackage

// File: rtl/pcseq_ras.sv
// Return-address stack: small LIFO, push and pop never requested together.
module pcseq_ras #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ADDR_W-1:0]       data_in,
    output logic [ADDR_W-1:0]       data_out,
    output logic [$clog2(DEPTH):0]  depth,
    output logic                    full,
    output logic                    empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     top;

    // Status and top-of-stack read
    always_comb begin
        full     = (cnt == CW'(DEPTH));
        empty    = (cnt == '0);
        top      = PW'(cnt - CW'(1));
        data_out = mem[top];
        depth    = cnt;
    end

    // Entry count; overflowing pushes and underflowing pops are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Storage write; contents are meaningless above the count so no reset
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[cnt[PW-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the program counter: increment, branch, jump,
// call/return via a return-address stack, imem stall and halt/resume.
// Optional interrupt entry is built when PCSEQ_IRQ_EN is defined.
module pc_sequencer #(
    parameter int unsigned            ADDR_W    = pcseq_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]      RESET_VEC = pcseq_pkg::RESET_VEC,
    parameter int unsigned            RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0]      IRQ_VEC   = pcseq_pkg::IRQ_VEC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             pc_cur,
    input  logic                          imem_ready,
    input  logic                          br_en,
    input  logic [ADDR_W-1:0]             br_target,
    input  logic                          jmp_en,
    input  logic                          call_en,
    input  logic                          ret_en,
    input  logic [ADDR_W-1:0]             jmp_target,
    input  logic                          halt_req,
    input  logic                          resume,
`ifdef PCSEQ_IRQ_EN
    input  logic                          irq,
`endif
    output logic [ADDR_W-1:0]             next_addr,
    output logic                          fetch_req,
    output logic                          halted,
    output logic [$clog2(RAS_DEPTH):0]    ras_depth,
    output logic                          ras_err
);
    import pcseq_pkg::*;

    state_t            state, state_next;
    sel_t              sel;
    logic              ras_push, ras_pop, ras_full, ras_empty, err_set;
    logic [ADDR_W-1:0] push_data, ras_top, pc_inc;

    assign pc_inc = pc_cur + ADDR_W'(1);

    pcseq_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .data_in  (push_data),
        .data_out (ras_top),
        .depth    (ras_depth),
        .full     (ras_full),
        .empty    (ras_empty)
    );

`ifdef PCSEQ_IRQ_EN
    logic irq_mask, mask_set, mask_clr;

    // Interrupt mask: set on interrupt entry, cleared by the next return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_mask <= 1'b0;
        end else if (mask_set) begin
            irq_mask <= 1'b1;
        end else if (mask_clr) begin
            irq_mask <= 1'b0;
        end
    end
`endif

    // State register and sticky stack-error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RST;
            ras_err <= 1'b0;
        end else begin
            state <= state_next;
            if (err_set) begin
                ras_err <= 1'b1;
            end
        end
    end

    // Next-state, source select and stack control
    always_comb begin
        state_next = state;
        sel        = SEL_HOLD;
        fetch_req  = 1'b0;
        halted     = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        err_set    = 1'b0;
        push_data  = pc_inc;
`ifdef PCSEQ_IRQ_EN
        mask_set   = 1'b0;
        mask_clr   = 1'b0;
`endif
        unique case (state)
            RST: begin
                sel        = SEL_RST;
                state_next = RUN;
            end
            RUN: begin
                fetch_req = 1'b1;
                if (!imem_ready) begin
                    state_next = STALL;
                end else if (halt_req) begin
                    state_next = HALT;
                end
`ifdef PCSEQ_IRQ_EN
                else if (irq && !irq_mask && !ras_full) begin
                    sel       = SEL_VEC;
                    ras_push  = 1'b1;
                    push_data = pc_cur;
                    mask_set  = 1'b1;
                end
`endif
                else if (ret_en) begin
`ifdef PCSEQ_IRQ_EN
                    mask_clr = 1'b1;
`endif
                    if (!ras_empty) begin
                        sel     = SEL_RET;
                        ras_pop = 1'b1;
                    end else begin
                        sel     = SEL_INC;
                        err_set = 1'b1;
                    end
                end else if (call_en) begin
                    sel      = SEL_CALL;
                    ras_push = 1'b1;
                    err_set  = ras_full;
                end else if (jmp_en) begin
                    sel = SEL_JMP;
                end else if (br_en) begin
                    sel = SEL_BR;
                end else begin
                    sel = SEL_INC;
                end
            end
            STALL: begin
                fetch_req = 1'b1;
                if (halt_req) begin
                    state_next = HALT;
                end else if (imem_ready) begin
                    state_next = RUN;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (resume && !halt_req) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RST;
            end
        endcase
    end

    // Next-address mux
    always_comb begin
        next_addr = pc_cur;
        unique case (sel)
            SEL_INC:  next_addr = pc_inc;
            SEL_BR:   next_addr = br_target;
            SEL_JMP:  next_addr = jmp_target;
            SEL_CALL: next_addr = jmp_target;
            SEL_RET:  next_addr = ras_top;
            SEL_HOLD: next_addr = pc_cur;
            SEL_VEC:  next_addr = IRQ_VEC;
            SEL_RST:  next_addr = RESET_VEC;
            default:  next_addr = pc_cur;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based model.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] pc_cur;
    logic       imem_ready;
    logic       br_en;
    logic [7:0] br_target;
    logic       jmp_en;
    logic       call_en;
    logic       ret_en;
    logic [7:0] jmp_target;
    logic       halt_req;
    logic       resume;
    logic [7:0] next_addr;
    logic       fetch_req;
    logic       halted;
    logic [2:0] ras_depth;
    logic       ras_err;
`ifdef PCSEQ_IRQ_EN
    logic       irq;
    assign irq = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [7:0] ras_q[$];
    bit         m_boot, m_halt, m_stall, m_err;
    logic [7:0] last_na;

    pc_sequencer #(
        .ADDR_W    (8),
        .RESET_VEC (8'h00),
        .RAS_DEPTH (4),
        .IRQ_VEC   (8'hF0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_cur     (pc_cur),
        .imem_ready (imem_ready),
        .br_en      (br_en),
        .br_target  (br_target),
        .jmp_en     (jmp_en),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .jmp_target (jmp_target),
        .halt_req   (halt_req),
        .resume     (resume),
`ifdef PCSEQ_IRQ_EN
        .irq        (irq),
`endif
        .next_addr  (next_addr),
        .fetch_req  (fetch_req),
        .halted     (halted),
        .ras_depth  (ras_depth),
        .ras_err    (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        ras_q.delete();
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_stall = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock: drive at the falling edge, check, advance model, cross rising edge
    task automatic cycle(input logic [7:0] pc, input logic rdy, input logic br,
                         input logic [7:0] bt, input logic jmp, input logic call,
                         input logic ret, input logic [7:0] jt, input logic hlt,
                         input logic res);
        logic [7:0] e_na;
        logic       e_fr, e_h;
        pc_cur = pc; imem_ready = rdy; br_en = br; br_target = bt; jmp_en = jmp;
        call_en = call; ret_en = ret; jmp_target = jt; halt_req = hlt; resume = res;
        #1;
        e_na = pc; e_fr = 1'b0; e_h = 1'b0;
        if (m_boot) begin
            e_na = 8'h00;
        end else if (m_halt) begin
            e_h = 1'b1;
        end else if (m_stall) begin
            e_fr = 1'b1;
        end else begin
            e_fr = 1'b1;
            if (rdy && !hlt) begin
                if (ret)       e_na = (ras_q.size() > 0) ? ras_q[$] : 8'(pc + 8'd1);
                else if (call) e_na = jt;
                else if (jmp)  e_na = jt;
                else if (br)   e_na = bt;
                else           e_na = 8'(pc + 8'd1);
            end
        end
        chk("next_addr", next_addr, e_na);
        chk("fetch_req", 8'(fetch_req), 8'(e_fr));
        chk("halted", 8'(halted), 8'(e_h));
        chk("ras_depth", 8'(ras_depth), 8'(ras_q.size()));
        chk("ras_err", 8'(ras_err), 8'(m_err));
        // Advance model to the post-edge state
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (res && !hlt) m_halt = 1'b0;
        end else if (m_stall) begin
            if (hlt) begin
                m_stall = 1'b0; m_halt = 1'b1;
            end else if (rdy) begin
                m_stall = 1'b0;
            end
        end else if (!rdy) begin
            m_stall = 1'b1;
        end else if (hlt) begin
            m_halt = 1'b1;
        end else if (ret) begin
            if (ras_q.size() > 0) void'(ras_q.pop_back());
            else m_err = 1'b1;
        end else if (call) begin
            if (ras_q.size() < 4) ras_q.push_back(8'(pc + 8'd1));
            else m_err = 1'b1;
        end
        last_na = e_na;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [7:0] pc);
        cycle(pc, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge
    task automatic reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk("arst_depth", 8'(ras_depth), 8'h00);
        chk("arst_err", 8'(ras_err), 8'h00);
        chk("arst_na", next_addr, 8'h00);
        chk("arst_fetch", 8'(fetch_req), 8'h00);
        chk("arst_halted", 8'(halted), 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; pc_cur = 8'h00; imem_ready = 1'b1; br_en = 1'b0; br_target = 8'h00;
        jmp_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; jmp_target = 8'h00;
        halt_req = 1'b0; resume = 1'b0;
        model_clear();
        #2;
        chk("rst_na", next_addr, 8'h00);
        chk("rst_fetch", 8'(fetch_req), 8'h00);
        chk("rst_halted", 8'(halted), 8'h00);
        chk("rst_depth", 8'(ras_depth), 8'h00);
        chk("rst_err", 8'(ras_err), 8'h00);
        #18;
        reset = 1'b1;

        // Boot, then fed-back increment and wrap
        idle(8'h00);
        idle(last_na);
        idle(last_na);
        idle(last_na);
        chk("step_03", last_na, 8'h03);
        idle(8'hFF);
        chk("wrap_ff", last_na, 8'h00);

        // Single call/return
        cycle(8'h10, 1, 0, 8'h00, 0, 1, 0, 8'h40, 0, 0);
        idle(8'h40);
        cycle(8'h45, 1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        chk("ret_11", last_na, 8'h11);
        idle(8'h11);

        // Overflow then underflow of the stack
        for (int i = 0; i < 5; i++)
            cycle(8'(8'h50 + i), 1, 0, 8'h00, 0, 1, 0, 8'(8'h60 + i), 0, 0);
        for (int i = 0; i < 5; i++)
            cycle(8'(8'h70 + i), 1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        chk("underflow_na", last_na, 8'h75);
        idle(8'h80);

        reset_pulse();
        idle(8'h00);

        // Pushed return address wraps
        cycle(8'hFF, 1, 0, 8'h00, 0, 1, 0, 8'h20, 0, 0);
        cycle(8'h20, 1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        chk("ret_wrap", last_na, 8'h00);

        // Stall with a branch pending, branch held through the exit cycle
        for (int i = 0; i < 3; i++)
            cycle(8'h22, 0, 1, 8'h77, 0, 0, 0, 8'h00, 0, 0);
        cycle(8'h22, 1, 1, 8'h77, 0, 0, 0, 8'h00, 0, 0);
        idle(8'h22);
        chk("stall_resume", last_na, 8'h23);

        // Halt beats branch; halt+resume stays halted; resume refetches
        cycle(8'h30, 1, 1, 8'h77, 0, 0, 0, 8'h00, 1, 0);
        idle(8'h30);
        cycle(8'h30, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1);
        cycle(8'h30, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        idle(8'h30);

        // Halt straight out of a stall
        cycle(8'h50, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        cycle(8'h50, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0);
        idle(8'h50);
        cycle(8'h50, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1);
        idle(8'h50);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            logic [7:0] pc;
            pc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : last_na;
            if ($urandom_range(0, 149) == 0) begin
                reset_pulse();
            end else begin
                cycle(pc,
                      $urandom_range(0, 4) != 0,
                      $urandom_range(0, 3) == 0, 8'($urandom),
                      $urandom_range(0, 5) == 0,
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 4) == 0, 8'($urandom),
                      $urandom_range(0, 14) == 0,
                      $urandom_range(0, 2) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
